timer_run_ctrl: RTL and testbench

// - Sequencer for the stopwatch TIMER block: turns start/stop and lap/clear

---
 rtl/timer_run_if.sv | 26 ++
 rtl/timer_run_ctrl.sv | 131 +++++++++++++
 tb/tb_timer_run_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_run_if.sv
// Button, TIMER-value and display bundle between the run controller and its neighbours.
// The master side drives mode/buttons/live values; the slave side returns mode2 and display.
interface timer_run_if;
  logic [1:0] mode1;
  logic       btn_ss;
  logic       btn_lap;
  logic [5:0] min_sw;
  logic [5:0] sec_sw;
  logic [3:0] secc_sw;
  logic [1:0] mode2;
  logic [5:0] disp_min;
  logic [5:0] disp_sec;
  logic [3:0] disp_secc;
  logic       lap_active;
  logic       max_reached;

  modport master (
    output mode1, btn_ss, btn_lap, min_sw, sec_sw, secc_sw,
    input  mode2, disp_min, disp_sec, disp_secc, lap_active, max_reached
  );

  modport slave (
    input  mode1, btn_ss, btn_lap, min_sw, sec_sw, secc_sw,
    output mode2, disp_min, disp_sec, disp_secc, lap_active, max_reached
  );
endinterface

// File: rtl/timer_run_ctrl.sv
// Stopwatch run sequencer: synchronised start/stop and lap/clear buttons drive the
// TIMER mode2 code, a lap-hold display, and an optional auto-stop at 59:59:9.
module timer_run_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter bit AUTO_STOP   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  timer_run_if.slave  bus
);

  localparam logic [1:0] M1_TIMER       = 2'b01;
  localparam logic [1:0] M2_TIMER_G     = 2'b00;
  localparam logic [1:0] M2_TIMER_START = 2'b01;
  localparam logic [1:0] M2_TIMER_STOP  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAP  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] ss_sync, lap_sync;
  logic                   ss_prev, lap_prev;
  logic                   ss_p, lap_p;
  logic                   at_max;
  logic                   set_max;

  logic [1:0] mode2_q;
  logic       lap_active_q;
  logic       max_reached_q;
  logic [5:0] disp_min_q;
  logic [5:0] disp_sec_q;
  logic [3:0] disp_secc_q;

  function automatic logic [1:0] mode2_of(input state_t s);
    case (s)
      S_RUN:   mode2_of = M2_TIMER_START;
      S_LAP:   mode2_of = M2_TIMER_START;
      S_STOP:  mode2_of = M2_TIMER_STOP;
      default: mode2_of = M2_TIMER_G;
    endcase
  endfunction

  // Button synchronisers and rising-edge history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_sync  <= '0;
      lap_sync <= '0;
      ss_prev  <= 1'b0;
      lap_prev <= 1'b0;
    end else begin
      ss_sync  <= {ss_sync[SYNC_STAGES-2:0], bus.btn_ss};
      lap_sync <= {lap_sync[SYNC_STAGES-2:0], bus.btn_lap};
      ss_prev  <= ss_sync[SYNC_STAGES-1];
      lap_prev <= lap_sync[SYNC_STAGES-1];
    end
  end

  assign ss_p   = ss_sync[SYNC_STAGES-1] & ~ss_prev;
  assign lap_p  = lap_sync[SYNC_STAGES-1] & ~lap_prev;
  assign at_max = (bus.min_sw == 6'd59) && (bus.sec_sw == 6'd59) && (bus.secc_sw == 4'd9);

  // Next state; a start/stop pulse shadows a coincident lap pulse
  always_comb begin
    state_next = state;
    set_max    = 1'b0;
    if (bus.mode1 != M1_TIMER) begin
      state_next = S_IDLE;
    end else if (AUTO_STOP && (state == S_RUN || state == S_LAP) && at_max) begin
      state_next = S_STOP;
      set_max    = 1'b1;
    end else if (ss_p) begin
      case (state)
        S_IDLE:  state_next = S_RUN;
        S_RUN:   state_next = S_STOP;
        S_LAP:   state_next = S_STOP;
        default: state_next = S_RUN;
      endcase
    end else if (lap_p) begin
      case (state)
        S_RUN:   state_next = S_LAP;
        S_LAP:   state_next = S_RUN;
        S_STOP:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // State and registered control outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      mode2_q       <= M2_TIMER_G;
      lap_active_q  <= 1'b0;
      max_reached_q <= 1'b0;
    end else begin
      state        <= state_next;
      mode2_q      <= mode2_of(state_next);
      lap_active_q <= (state_next == S_LAP);
      if (state_next == S_IDLE)
        max_reached_q <= 1'b0;
      else if (set_max)
        max_reached_q <= 1'b1;
    end
  end

  // Display: live with one-cycle lag except while LAP holds the captured value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_min_q  <= '0;
      disp_sec_q  <= '0;
      disp_secc_q <= '0;
    end else if (state != S_LAP) begin
      disp_min_q  <= bus.min_sw;
      disp_sec_q  <= bus.sec_sw;
      disp_secc_q <= bus.secc_sw;
    end
  end

  assign bus.mode2       = mode2_q;
  assign bus.lap_active  = lap_active_q;
  assign bus.max_reached = max_reached_q;
  assign bus.disp_min    = disp_min_q;
  assign bus.disp_sec    = disp_sec_q;
  assign bus.disp_secc   = disp_secc_q;

endmodule

// File: tb/tb_timer_run_ctrl.sv
// Directed bench for timer_run_ctrl: live TIMER values are driven as vectors and
// every expectation is a hand-computed constant.
module tb_timer_run_ctrl;

  localparam logic [1:0] M1_TIMER = 2'b01;
  localparam logic [1:0] M1_OTHER = 2'b00;
  localparam logic [1:0] G        = 2'b00;
  localparam logic [1:0] START    = 2'b01;
  localparam logic [1:0] STOP     = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  timer_run_if bus ();

  timer_run_ctrl #(.SYNC_STAGES(2), .AUTO_STOP(1'b1)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {mode2, lap_active, max_reached} and {min, sec, secc}
  logic [3:0]  ctl;
  logic [15:0] disp;
  assign ctl  = {bus.mode2, bus.lap_active, bus.max_reached};
  assign disp = {bus.disp_min, bus.disp_sec, bus.disp_secc};

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [5:0] m, input logic [5:0] s, input logic [3:0] c);
    bus.min_sw  = m;
    bus.sec_sw  = s;
    bus.secc_sw = c;
  endtask

  // Rising input takes effect on the third edge; release afterwards
  task automatic press(input logic ss, input logic lap);
    bus.btn_ss  = ss;
    bus.btn_lap = lap;
    tick(3);
    bus.btn_ss  = 1'b0;
    bus.btn_lap = 1'b0;
  endtask

  task automatic settle();
    tick(3);
  endtask

  task automatic test_reset();
    tick(2);
    if (ctl !== {G, 1'b0, 1'b0}) begin
      $display("FAIL reset_ctl: got %b expected %b", ctl, {G, 1'b0, 1'b0}); fails++;
    end
    checks++;
    if (disp !== 16'h0) begin
      $display("FAIL reset_disp: got %h expected %h", disp, 16'h0); fails++;
    end
    checks++;
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_start_stop();
    set_time(6'd0, 6'd0, 4'd0);
    bus.btn_ss = 1'b1;
    tick(2);
    if (ctl !== {G, 1'b0, 1'b0}) begin
      $display("FAIL ss_latency: got %b expected %b", ctl, {G, 1'b0, 1'b0}); fails++;
    end
    checks++;
    tick(1);
    bus.btn_ss = 1'b0;
    if (ctl !== {START, 1'b0, 1'b0}) begin
      $display("FAIL ss_start: got %b expected %b", ctl, {START, 1'b0, 1'b0}); fails++;
    end
    checks++;
    settle();
    set_time(6'd0, 6'd1, 4'd0);
    press(1'b1, 1'b0);
    if (ctl !== {STOP, 1'b0, 1'b0}) begin
      $display("FAIL ss_stop: got %b expected %b", ctl, {STOP, 1'b0, 1'b0}); fails++;
    end
    checks++;
    settle();
    if (disp !== {6'd0, 6'd1, 4'd0}) begin
      $display("FAIL ss_stop_disp: got %h expected %h", disp, {6'd0, 6'd1, 4'd0}); fails++;
    end
    checks++;
    bus.btn_ss = 1'b1;
    tick(3);
    if (ctl !== {START, 1'b0, 1'b0}) begin
      $display("FAIL ss_restart: got %b expected %b", ctl, {START, 1'b0, 1'b0}); fails++;
    end
    checks++;
    tick(10);
    if (ctl !== {START, 1'b0, 1'b0}) begin
      $display("FAIL ss_held: got %b expected %b", ctl, {START, 1'b0, 1'b0}); fails++;
    end
    checks++;
    bus.btn_ss = 1'b0;
    settle();
  endtask

  task automatic test_lap();
    set_time(6'd0, 6'd3, 4'd2);
    tick(2);
    press(1'b0, 1'b1);
    if (ctl !== {START, 1'b1, 1'b0}) begin
      $display("FAIL lap_enter: got %b expected %b", ctl, {START, 1'b1, 1'b0}); fails++;
    end
    checks++;
    set_time(6'd0, 6'd3, 4'd7);
    settle();
    if (disp !== {6'd0, 6'd3, 4'd2}) begin
      $display("FAIL lap_hold: got %h expected %h", disp, {6'd0, 6'd3, 4'd2}); fails++;
    end
    checks++;
    set_time(6'd0, 6'd4, 4'd0);
    press(1'b0, 1'b1);
    if (ctl !== {START, 1'b0, 1'b0}) begin
      $display("FAIL lap_exit: got %b expected %b", ctl, {START, 1'b0, 1'b0}); fails++;
    end
    checks++;
    settle();
    if (disp !== {6'd0, 6'd4, 4'd0}) begin
      $display("FAIL lap_resume: got %h expected %h", disp, {6'd0, 6'd4, 4'd0}); fails++;
    end
    checks++;
    set_time(6'd0, 6'd4, 4'd1);
    tick(1);
    if (disp !== {6'd0, 6'd4, 4'd1}) begin
      $display("FAIL lap_live_lag: got %h expected %h", disp, {6'd0, 6'd4, 4'd1}); fails++;
    end
    checks++;
  endtask

  task automatic test_clear();
    set_time(6'd0, 6'd7, 4'd4);
    press(1'b1, 1'b0);
    settle();
    if ({ctl, disp} !== {STOP, 1'b0, 1'b0, 6'd0, 6'd7, 4'd4}) begin
      $display("FAIL clear_stop: got %h expected %h", {ctl, disp}, {STOP, 1'b0, 1'b0, 6'd0, 6'd7, 4'd4}); fails++;
    end
    checks++;
    press(1'b0, 1'b1);
    set_time(6'd0, 6'd0, 4'd0);
    if (ctl !== {G, 1'b0, 1'b0}) begin
      $display("FAIL clear_idle: got %b expected %b", ctl, {G, 1'b0, 1'b0}); fails++;
    end
    checks++;
    settle();
    if (disp !== 16'h0) begin
      $display("FAIL clear_disp: got %h expected %h", disp, 16'h0); fails++;
    end
    checks++;
  endtask

  task automatic test_simultaneous();
    press(1'b1, 1'b0);
    settle();
    press(1'b1, 1'b1);
    if (ctl !== {STOP, 1'b0, 1'b0}) begin
      $display("FAIL simul_stop: got %b expected %b", ctl, {STOP, 1'b0, 1'b0}); fails++;
    end
    checks++;
    settle();
    if (ctl !== {STOP, 1'b0, 1'b0}) begin
      $display("FAIL simul_lap_dropped: got %b expected %b", ctl, {STOP, 1'b0, 1'b0}); fails++;
    end
    checks++;
    press(1'b0, 1'b1);
    settle();
  endtask

  task automatic test_auto_stop();
    set_time(6'd59, 6'd59, 4'd7);
    press(1'b1, 1'b0);
    settle();
    set_time(6'd59, 6'd59, 4'd8);
    tick(1);
    if (ctl !== {START, 1'b0, 1'b0}) begin
      $display("FAIL auto_pre: got %b expected %b", ctl, {START, 1'b0, 1'b0}); fails++;
    end
    checks++;
    set_time(6'd59, 6'd59, 4'd9);
    tick(1);
    if (ctl !== {STOP, 1'b0, 1'b1}) begin
      $display("FAIL auto_stop: got %b expected %b", ctl, {STOP, 1'b0, 1'b1}); fails++;
    end
    checks++;
    tick(120);
    if ({ctl, disp} !== {STOP, 1'b0, 1'b1, 6'd59, 6'd59, 4'd9}) begin
      $display("FAIL auto_hold: got %h expected %h", {ctl, disp}, {STOP, 1'b0, 1'b1, 6'd59, 6'd59, 4'd9}); fails++;
    end
    checks++;
    press(1'b1, 1'b0);
    set_time(6'd0, 6'd0, 4'd0);
    if (ctl !== {START, 1'b0, 1'b1}) begin
      $display("FAIL auto_restart_sticky: got %b expected %b", ctl, {START, 1'b0, 1'b1}); fails++;
    end
    checks++;
    settle();
    press(1'b1, 1'b0);
    settle();
    press(1'b0, 1'b1);
    if (ctl !== {G, 1'b0, 1'b0}) begin
      $display("FAIL auto_clear: got %b expected %b", ctl, {G, 1'b0, 1'b0}); fails++;
    end
    checks++;
    settle();
  endtask

  task automatic test_mode_exit();
    press(1'b1, 1'b0);
    settle();
    set_time(6'd0, 6'd10, 4'd0);
    press(1'b0, 1'b1);
    settle();
    if (ctl !== {START, 1'b1, 1'b0}) begin
      $display("FAIL mode_in_lap: got %b expected %b", ctl, {START, 1'b1, 1'b0}); fails++;
    end
    checks++;
    bus.mode1 = M1_OTHER;
    tick(1);
    if (ctl !== {G, 1'b0, 1'b0}) begin
      $display("FAIL mode_exit: got %b expected %b", ctl, {G, 1'b0, 1'b0}); fails++;
    end
    checks++;
    press(1'b1, 1'b0);
    settle();
    press(1'b0, 1'b1);
    settle();
    bus.mode1 = M1_TIMER;
    tick(2);
    if ({ctl, disp} !== {G, 1'b0, 1'b0, 6'd0, 6'd10, 4'd0}) begin
      $display("FAIL mode_ignored: got %h expected %h", {ctl, disp}, {G, 1'b0, 1'b0, 6'd0, 6'd10, 4'd0}); fails++;
    end
    checks++;
  endtask

  task automatic test_reset_mid_run();
    press(1'b1, 1'b0);
    set_time(6'd12, 6'd34, 4'd5);
    settle();
    if (disp !== {6'd12, 6'd34, 4'd5}) begin
      $display("FAIL rst_pre_disp: got %h expected %h", disp, {6'd12, 6'd34, 4'd5}); fails++;
    end
    checks++;
    #2;
    rst = 1'b1;
    #1;
    if ({ctl, disp} !== {G, 1'b0, 1'b0, 16'h0}) begin
      $display("FAIL rst_async: got %h expected %h", {ctl, disp}, {G, 1'b0, 1'b0, 16'h0}); fails++;
    end
    checks++;
    tick(1);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    bus.mode1   = M1_TIMER;
    bus.btn_ss  = 1'b0;
    bus.btn_lap = 1'b0;
    set_time(6'd0, 6'd0, 4'd0);
    test_reset();
    test_start_stop();
    test_lap();
    test_clear();
    test_simultaneous();
    test_auto_stop();
    test_mode_exit();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
